// File: rtl/dht_reader.sv
// dht_reader: single-wire DHT11/DHT22 sensor reader with an internal microsecond prescaler,
// open-drain bus drive and per-phase error codes. Define DHT_CHECKSUM_EN to validate the checksum byte.
module dht_reader #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned START_LOW_US    = 19000,
    parameter int unsigned RELEASE_US      = 20,
    parameter int unsigned RESP_TIMEOUT_US = 100,
    parameter int unsigned BIT_THRESH_US   = 50,
    parameter int unsigned BIT_TIMEOUT_US  = 100,
    parameter int unsigned GUARD_US        = 100
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         dht_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err_code,
    output logic [39:0] data_out
);

    localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W      = $clog2(CYC_PER_US);
    localparam int unsigned US_W       = 20;

    localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(CYC_PER_US - 1);
    localparam logic [US_W-1:0]  START_LOW_T   = US_W'(START_LOW_US);
    localparam logic [US_W-1:0]  RELEASE_T     = US_W'(RELEASE_US);
    localparam logic [US_W-1:0]  RESP_TO_T     = US_W'(RESP_TIMEOUT_US);
    localparam logic [US_W-1:0]  BIT_THRESH_T  = US_W'(BIT_THRESH_US);
    localparam logic [US_W-1:0]  BIT_TO_T      = US_W'(BIT_TIMEOUT_US);
    localparam logic [US_W-1:0]  GUARD_T       = US_W'(GUARD_US);

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_NO_RESP   = 3'd1;
    localparam logic [2:0] ERR_RESP_LOW  = 3'd2;
    localparam logic [2:0] ERR_RESP_HIGH = 3'd3;
    localparam logic [2:0] ERR_BIT_LOW   = 3'd4;
    localparam logic [2:0] ERR_BIT_HIGH  = 3'd5;
`ifdef DHT_CHECKSUM_EN
    localparam logic [2:0] ERR_CHECKSUM  = 3'd6;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_WAIT_RESP,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_GUARD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        sync;
    logic              line;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [US_W-1:0]   us_cnt;
    logic [5:0]        bit_idx;
    logic [39:0]       shift_reg;
    logic [2:0]        err_pend;
    logic              err_set;
    logic [2:0]        err_val;
    logic              shift_en;
    logic              bit_val;

    assign line    = sync[1];
    assign tick    = (pre_cnt == PRE_LAST);
    assign bit_val = (us_cnt > BIT_THRESH_T);
    assign busy    = (state != S_IDLE);

    // Open-drain: only ever pull low; the bus pull-up supplies the high level.
    assign dht_data = (state == S_START_LOW) ? 1'b0 : 1'bz;

`ifdef DHT_CHECKSUM_EN
    logic [7:0] sum;
    assign sum = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Edge detection is level-based on the synchronized line; an edge wins over a same-cycle timeout.
    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        err_val    = ERR_OK;
        shift_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_START_LOW;
            end
            S_START_LOW: begin
                if (us_cnt >= START_LOW_T) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (us_cnt >= RELEASE_T) state_next = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (!line) begin
                    state_next = S_RESP_LOW;
                end else if (us_cnt >= RESP_TO_T) begin
                    state_next = S_GUARD;
                    err_set    = 1'b1;
                    err_val    = ERR_NO_RESP;
                end
            end
            S_RESP_LOW: begin
                if (line) begin
                    state_next = S_RESP_HIGH;
                end else if (us_cnt >= RESP_TO_T) begin
                    state_next = S_GUARD;
                    err_set    = 1'b1;
                    err_val    = ERR_RESP_LOW;
                end
            end
            S_RESP_HIGH: begin
                if (!line) begin
                    state_next = S_BIT_LOW;
                end else if (us_cnt >= RESP_TO_T) begin
                    state_next = S_GUARD;
                    err_set    = 1'b1;
                    err_val    = ERR_RESP_HIGH;
                end
            end
            S_BIT_LOW: begin
                if (line) begin
                    state_next = S_BIT_HIGH;
                end else if (us_cnt >= BIT_TO_T) begin
                    state_next = S_GUARD;
                    err_set    = 1'b1;
                    err_val    = ERR_BIT_LOW;
                end
            end
            S_BIT_HIGH: begin
                if (!line) begin
                    shift_en   = 1'b1;
                    state_next = (bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
                end else if (us_cnt >= BIT_TO_T) begin
                    state_next = S_GUARD;
                    err_set    = 1'b1;
                    err_val    = ERR_BIT_HIGH;
                end
            end
            S_CHECK: begin
                state_next = S_GUARD;
`ifdef DHT_CHECKSUM_EN
                if (sum != shift_reg[7:0]) begin
                    err_set = 1'b1;
                    err_val = ERR_CHECKSUM;
                end
`else
                // Every complete frame is accepted when checksum validation is not built in.
`endif
            end
            S_GUARD: begin
                if (us_cnt >= GUARD_T) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            pre_cnt   <= '0;
            us_cnt    <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            err_pend  <= ERR_OK;
            done      <= 1'b0;
            err_code  <= ERR_OK;
            data_out  <= '0;
        end else begin
            sync <= {sync[0], dht_data};
            done <= 1'b0;

            if (state_next != state || state == S_IDLE) begin
                pre_cnt <= '0;
                us_cnt  <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                us_cnt  <= us_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (state == S_IDLE && start) begin
                bit_idx   <= '0;
                shift_reg <= '0;
                err_pend  <= ERR_OK;
            end

            if (shift_en) begin
                shift_reg <= {shift_reg[38:0], bit_val};
                bit_idx   <= bit_idx + 1'b1;
            end

            if (err_set) err_pend <= err_val;

            if (state == S_GUARD && state_next == S_IDLE) begin
                done     <= 1'b1;
                err_code <= err_pend;
                if (err_pend == ERR_OK) data_out <= shift_reg;
            end
        end
    end

endmodule

// File: doc/dht_reader.md
# dht_reader

Parametrised single-wire (DHT11/DHT22-class) sensor reader for the monitoring FPGA. Runs from the system clock with an internal microsecond prescaler instead of a dedicated 1 µs clock, drives the bus open-drain and returns the 40-bit frame. Adds a per-phase error code and optional checksum validation. Sits between the command/UART controller (start/done handshake) and the sensor pin.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; CLK_HZ/1_000_000 must be an integer ≥ 2.
- START_LOW_US, 19000, host start pulse low time; 1000 is sufficient for DHT22.
- RELEASE_US, 20, host release time before sampling for the sensor response.
- RESP_TIMEOUT_US, 100, max duration of each response phase and of the wait for the response.
- BIT_THRESH_US, 50, high time strictly above this decodes as 1.
- BIT_TIMEOUT_US, 100, max low or high time of a data bit.
- GUARD_US, 100, bus-idle time after each transaction before done.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dht_data  inout  1  sensor bus, open-drain: drives 0 or Z only.
- start  in  1  begin transaction; sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at transaction end.
- err_code  out  3  result of last transaction; valid with done, held until next done.
- data_out  out  40  {hum_int, hum_frac, temp_int, temp_frac, checksum}; updated only on err_code 0.

## Operation
- dht_data is sampled through a 2-flop synchronizer; all decisions use the synchronized value.
- Prescaler generates a 1-cycle tick every CLK_HZ/1e6 cycles. Prescaler and µs counter are cleared on every state entry.
- States and transitions:
  - IDLE: bus Z. start=1 → START_LOW; bit index and shift register cleared.
  - START_LOW: drive 0; after START_LOW_US ticks → RELEASE.
  - RELEASE: bus Z; after RELEASE_US ticks → WAIT_RESP.
  - WAIT_RESP: line 0 → RESP_LOW; RESP_TIMEOUT_US ticks elapse → GUARD, err 1.
  - RESP_LOW: line 1 → RESP_HIGH; timeout → GUARD, err 2.
  - RESP_HIGH: line 0 → BIT_LOW; timeout → GUARD, err 3.
  - BIT_LOW: line 1 → BIT_HIGH; timeout → GUARD, err 4.
  - BIT_HIGH: line 0 → shift in (count > BIT_THRESH_US), MSB first; after bit 39 → CHECK, else BIT_LOW. Timeout → GUARD, err 5.
  - CHECK: one cycle; checksum test (see Configuration); → GUARD.
  - GUARD: bus Z; after GUARD_US ticks → IDLE, pulse done, latch err_code, load data_out when err 0.
- err_code: 0 ok, 1 no response, 2 response-low timeout, 3 response-high timeout, 4 bit-low timeout, 5 bit-high timeout, 6 checksum mismatch, 7 unused.
- Timeout priority: an edge and a timeout in the same cycle count as the edge.
- start while busy is ignored; start held high re-triggers only after done.
- Checksum arithmetic: sum of four data bytes modulo 256 (8-bit wrap) against byte 4.

## Timing
- Reset: state IDLE, bus Z, busy 0, done 0, err_code 0, data_out 0, counters 0. rst mid-transaction releases bus in the next cycle and aborts without a done pulse.
- start sampled high in IDLE at cycle N → bus driven low and busy 1 from cycle N+1.
- Phase durations accurate to ±1 tick; synchronizer adds 2 cycles of edge latency.
- done high exactly one cycle; busy falls in the same cycle done rises.
- Nominal DHT11 transaction: ≈19 ms + ~4–5 ms frame + 100 µs guard.

## Configuration
- DHT_CHECKSUM_EN defined: CHECK compares checksum; mismatch → err 6, data_out not updated.
- Undefined: CHECK always passes; err 6 never produced; data_out loaded after any complete 40-bit frame.

## Test plan
- Sensor model returns 0x3A,0x00,0x1C,0x05,0x5B with 26 µs/70 µs highs → err 0, data_out 0x3A001C055B, single done pulse, busy then 0.
- Sensor silent → err 1 after START_LOW+RELEASE+100 µs+GUARD; data_out keeps previous value.
- Sensor holds line low after response → err 2; line held high at response-high → err 3; line stuck high mid-bit 12 → err 5.
- Frame with checksum 0x5C: with DHT_CHECKSUM_EN → err 6, data_out unchanged; without → err 0, data_out 0x3A001C055C.
- Bytes 0xFF,0xFF,0xFF,0xFF,0xFC → checksum wrap accepted, err 0.
- rst asserted during BIT_HIGH of bit 20 → bus Z next cycle, busy 0, no done; subsequent start completes normally.
